// File: rtl/hack_rom_loader.sv
// HACK boot loader: framed byte stream -> instruction ROM writes.
// Holds the CPU in reset until the image is written and checksummed.
module hack_rom_loader #(
   parameter int ADDR_W         = 15,
   parameter int MAX_WORDS      = 32768,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [15:0]       rom_data,
   output logic              rom_we,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0]   MAX_CNT  = 17'(MAX_WORDS);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_HDR_HI,
      S_HDR_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t state;
   state_t state_nx;

   logic [7:0]    hi_byte;
   logic [15:0]   count;
   logic [7:0]    sum;
   logic [TW-1:0] idle_cnt;

   logic          in_frame;
   logic          xfer;
   logic          reload_ok;
   logic          timed_out;
   logic          last_word;
   logic          too_big;
   logic [15:0]   hdr_count;
   logic [7:0]    sum_nx;

   assign in_frame  = (state == S_HDR_LO) || (state == S_DATA_HI) ||
                      (state == S_DATA_LO) || (state == S_CHECK);
   assign in_ready  = in_frame || (state == S_HDR_HI);
   assign busy      = in_frame;
   assign xfer      = in_valid && in_ready;
   assign reload_ok = reload && ((state == S_DONE) || (state == S_ERROR));

   assign hdr_count = {hi_byte, in_data};
   assign too_big   = {1'b0, hdr_count} > MAX_CNT;
   assign sum_nx    = sum + in_data;
   assign last_word = (words_loaded + 16'd1) == count;
   assign timed_out = in_frame && !xfer && (idle_cnt == TMO_LAST);

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_HDR_HI;
      end else begin
         state <= state_nx;
      end
   end

   // next-state decode and status outputs
   always_comb begin
      state_nx  = state;
      cpu_reset = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      unique case (state)
         S_HDR_HI: begin
            if (xfer) state_nx = S_HDR_LO;
         end
         S_HDR_LO: begin
            if (xfer) begin
               if (too_big)
                  state_nx = S_ERROR;
               else if (hdr_count == 16'd0)
                  state_nx = S_CHECK;
               else
                  state_nx = S_DATA_HI;
            end else if (timed_out) begin
               state_nx = S_ERROR;
            end
         end
         S_DATA_HI: begin
            if (xfer)
               state_nx = S_DATA_LO;
            else if (timed_out)
               state_nx = S_ERROR;
         end
         S_DATA_LO: begin
            if (xfer)
               state_nx = last_word ? S_CHECK : S_DATA_HI;
            else if (timed_out)
               state_nx = S_ERROR;
         end
         S_CHECK: begin
            if (xfer)
               state_nx = (sum_nx == 8'd0) ? S_DONE : S_ERROR;
            else if (timed_out)
               state_nx = S_ERROR;
         end
         S_DONE: begin
            cpu_reset = 1'b0;
            done      = 1'b1;
            if (reload) state_nx = S_HDR_HI;
         end
         S_ERROR: begin
            error = 1'b1;
            if (reload) state_nx = S_HDR_HI;
         end
         default: begin
            state_nx = S_HDR_HI;
         end
      endcase
   end

   // inter-byte idle counter, only while a frame is open
   always_ff @(posedge clk) begin
      if (reset || !in_frame || xfer) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

   // running 8-bit checksum over every accepted frame byte
   always_ff @(posedge clk) begin
      if (reset || reload_ok) begin
         sum <= 8'd0;
      end else if (xfer) begin
         sum <= (state == S_HDR_HI) ? in_data : sum_nx;
      end
   end

   // header/high-byte capture
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_byte <= 8'd0;
         count   <= 16'd0;
      end else if (xfer) begin
         case (state)
            S_HDR_HI:  hi_byte <= in_data;
            S_HDR_LO:  count   <= hdr_count;
            S_DATA_HI: hi_byte <= in_data;
            default:   hi_byte <= hi_byte;
         endcase
      end
   end

   // registered ROM write port; one strobe per completed word
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_we       <= 1'b0;
         rom_addr     <= '0;
         rom_data     <= 16'd0;
         words_loaded <= 16'd0;
      end else begin
         rom_we <= 1'b0;
         if (reload_ok) begin
            words_loaded <= 16'd0;
         end else if (xfer && (state == S_DATA_LO)) begin
            rom_we       <= 1'b1;
            rom_addr     <= ADDR_W'(words_loaded);
            rom_data     <= {hi_byte, in_data};
            words_loaded <= words_loaded + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: directed frames plus random frames
// checked against a frame-level reference model.
module tb_hack_rom_loader;

   localparam int MAXW = 4;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        reload;
   logic [14:0] rom_addr;
   logic [15:0] rom_data;
   logic        rom_we;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int checks = 0;
   int errors = 0;

   logic [7:0]  fb[$];
   int          fg[$];
   logic [30:0] cap[$];
   logic [30:0] exp_w[$];
   int          exp_acc;
   bit          exp_done;
   bit          exp_err;
   int          got_acc;

   hack_rom_loader #(
      .ADDR_W(15),
      .MAX_WORDS(MAXW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .reload(reload),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .rom_we(rom_we),
      .cpu_reset(cpu_reset),
      .busy(busy),
      .done(done),
      .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // capture every ROM write strobe
   always @(negedge clk) begin
      if (rom_we === 1'b1) cap.push_back({rom_addr, rom_data});
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // frame-level reference: which bytes are taken, what is written, outcome
   task automatic model();
      logic [7:0] s;
      int n;
      exp_w.delete();
      exp_done = 0;
      exp_err  = 0;
      exp_acc  = 0;
      s = 8'd0;
      n = 0;
      for (int i = 0; i < fb.size(); i++) begin
         if (i > 0 && fg[i] >= TMO) begin
            exp_err = 1;
            break;
         end
         exp_acc++;
         s = s + fb[i];
         if (i == 1) begin
            n = int'({fb[0], fb[1]});
            if (n > MAXW) begin
               exp_err = 1;
               break;
            end
         end else if (i >= 2 && i < 2 + 2 * n) begin
            if (i % 2 == 1)
               exp_w.push_back({15'((i - 2) / 2), fb[i-1], fb[i]});
         end else if (i >= 2) begin
            if (s == 8'd0) exp_done = 1;
            else exp_err = 1;
            break;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      if (in_ready === 1'b1) got_acc++;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic feed_from(input int start);
      for (int i = start; i < fb.size(); i++) send_byte(fb[i], fg[i]);
   endtask

   task automatic check_frame(input string tag);
      chk({tag, " accepted"}, got_acc, exp_acc);
      chk({tag, " done"}, done, exp_done);
      chk({tag, " error"}, error, exp_err);
      chk({tag, " cpu_reset"}, cpu_reset, !exp_done);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " in_ready"}, in_ready, 0);
      chk({tag, " words_loaded"}, words_loaded, exp_w.size());
      chk({tag, " nwrites"}, cap.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < cap.size(); i++)
         chk({tag, " write"}, cap[i], exp_w[i]);
   endtask

   task automatic run_frame(input string tag);
      model();
      cap.delete();
      got_acc = 0;
      feed_from(0);
      check_frame(tag);
   endtask

   task automatic do_reload(input string tag);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk({tag, " cpu_reset"}, cpu_reset, 1);
      chk({tag, " done"}, done, 0);
      chk({tag, " error"}, error, 0);
      chk({tag, " words_loaded"}, words_loaded, 0);
      chk({tag, " in_ready"}, in_ready, 1);
      chk({tag, " busy"}, busy, 0);
      cap.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " in_ready"}, in_ready, 1);
      chk({tag, " rom_we"}, rom_we, 0);
      chk({tag, " rom_addr"}, rom_addr, 0);
      chk({tag, " rom_data"}, rom_data, 0);
      chk({tag, " cpu_reset"}, cpu_reset, 1);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " error"}, error, 0);
      chk({tag, " words_loaded"}, words_loaded, 0);
   endtask

   task automatic set_gaps(input int g);
      fg.delete();
      for (int i = 0; i < fb.size(); i++) fg.push_back(g);
   endtask

   task automatic append_chk(input bit corrupt);
      logic [7:0] s;
      s = 8'd0;
      foreach (fb[i]) s = s + fb[i];
      s = 8'd0 - s;
      if (corrupt) s = s + 8'($urandom_range(1, 255));
      fb.push_back(s);
   endtask

   task automatic gen_random();
      int n;
      int nw;
      int r;
      logic [15:0] cnt;
      fb.delete();
      fg.delete();
      n = int'($urandom_range(0, 5));
      cnt = (n == 5) ? 16'($urandom_range(5, 65535)) : 16'(n);
      fb.push_back(cnt[15:8]);
      fb.push_back(cnt[7:0]);
      nw = (int'(cnt) > MAXW) ? 1 : int'(cnt);
      for (int i = 0; i < 2 * nw; i++) fb.push_back(8'($urandom));
      append_chk($urandom_range(0, 3) == 0);
      for (int i = 0; i < fb.size(); i++) begin
         r = int'($urandom_range(0, 19));
         if (r < 14) fg.push_back(0);
         else if (r < 18) fg.push_back(int'($urandom_range(1, 15)));
         else fg.push_back(int'($urandom_range(16, 18)));
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      reload   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;

      // normal load with cycle-exact write and release checks
      fb = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h07, 8'hFB};
      set_gaps(0);
      model();
      cap.delete();
      got_acc = 0;
      for (int i = 0; i < 4; i++) send_byte(fb[i], 0);
      chk("norm we0", rom_we, 1);
      chk("norm addr0", rom_addr, 0);
      chk("norm data0", rom_data, 16'hEC10);
      chk("norm wl1", words_loaded, 1);
      send_byte(fb[4], 0);
      chk("norm we idle", rom_we, 0);
      send_byte(fb[5], 0);
      chk("norm we1", rom_we, 1);
      chk("norm addr1", rom_addr, 1);
      chk("norm data1", rom_data, 16'h0007);
      chk("norm pre done", done, 0);
      chk("norm pre cpu_reset", cpu_reset, 1);
      send_byte(fb[6], 0);
      chk("norm done", done, 1);
      chk("norm cpu_reset", cpu_reset, 0);
      check_frame("norm");
      do_reload("reload1");

      fb = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h07, 8'hFA};
      set_gaps(0);
      run_frame("badchk");
      do_reload("reload2");

      fb = '{8'h00, 8'h00, 8'h00};
      set_gaps(0);
      run_frame("empty");
      do_reload("reload3");

      // oversize count: error right after the count bytes
      fb = '{8'h00, 8'h05, 8'h11, 8'h22, 8'h33};
      set_gaps(0);
      model();
      cap.delete();
      got_acc = 0;
      send_byte(fb[0], 0);
      send_byte(fb[1], 0);
      chk("over error", error, 1);
      chk("over in_ready", in_ready, 0);
      chk("over rom_we", rom_we, 0);
      feed_from(2);
      check_frame("over");
      do_reload("reload4");

      fb = '{8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h07, 8'hFB};
      set_gaps(15);
      fg[0] = 20;
      run_frame("stall15");
      do_reload("reload5");

      fb = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h87};
      set_gaps(0);
      fg[3] = 16;
      run_frame("timeout16");
      do_reload("reload6");

      fb = '{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22,
             8'h33, 8'h33, 8'h44, 8'h44};
      append_chk(0);
      set_gaps(0);
      run_frame("maxwords");
      do_reload("reload7");

      // reset mid-frame after the first word has been written
      fb = '{8'h00, 8'h02, 8'hEC, 8'h10};
      got_acc = 0;
      for (int i = 0; i < 4; i++) send_byte(fb[i], 0);
      chk("midrst we", rom_we, 1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("midrst");
      reset = 1'b0;
      fb = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hB9};
      set_gaps(0);
      run_frame("afterrst");
      do_reload("reload8");

      fb = '{8'h00, 8'h01, 8'h56, 8'h78};
      append_chk(0);
      set_gaps(0);
      run_frame("second");
      do_reload("reload9");

      for (int k = 0; k < 30; k++) begin
         gen_random();
         run_frame($sformatf("rand%0d", k));
         do_reload($sformatf("rrel%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Boot loader directly upstream of the HACK CPU and its instruction ROM.
- Receives a framed byte stream (from the UART RX block) over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word into the instruction ROM write port, holding the CPU in reset until the full image has been loaded and the checksum verified.
- Releases the CPU on success; on any framing, size or timeout failure, latches an error and keeps the CPU held.

Parameters:
- ADDR_W, 15, ROM address width; matches the CPU instruction address.
- MAX_WORDS, 32768, largest accepted image in words; must be ≤ 2^ADDR_W.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between accepted bytes once a frame has started.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  received byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle request to restart loading from DONE or ERROR.
- rom_addr  out  ADDR_W  ROM write address.
- rom_data  out  16  ROM write data.
- rom_we  out  1  ROM write strobe, one cycle per word.
- cpu_reset  out  1  drives the HACK CPU reset input.
- busy  out  1  a frame is in progress (first header byte accepted, not yet DONE/ERROR).
- done  out  1  image loaded and verified.
- error  out  1  load failed.
- words_loaded  out  16  number of words written in the current frame.

Behaviour:
- Frame format: CNT_HI, CNT_LO, then CNT words (each HI byte then LO byte), then CHK.
  - CHK is chosen so that the 8-bit modular sum of every frame byte, including CHK, equals 0.
- Handshake: a byte transfers on a rising edge when in_valid && in_ready. in_data is not sampled otherwise.
- States and transitions:
  - HDR_HI (reset state) -> HDR_LO on transfer.
  - HDR_LO -> on transfer, latch count:
    - count > MAX_WORDS -> ERROR;
    - count == 0 -> CHECK;
    - otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO on transfer.
  - DATA_LO -> on transfer, issue a write:
    - if it was the last word -> CHECK;
    - else -> DATA_HI.
  - CHECK -> on transfer:
    - sum == 0 -> DONE;
    - else -> ERROR.
  - DONE, ERROR: held until reload or reset.
  - reload in DONE/ERROR -> HDR_HI: clears address, sum, words_loaded, done and error; reasserts cpu_reset the next cycle.
  - reload in any other state is ignored.
- in_ready = 1 in HDR_HI, HDR_LO, DATA_HI, DATA_LO and CHECK; 0 in DONE and ERROR. Back-to-back bytes every cycle are sustained with no bubbles.
- Write timing (all ROM outputs registered):
  - The cycle after a DATA_LO transfer: rom_we = 1, rom_data = {HI, LO}, rom_addr = word index (0 for the first word).
  - words_loaded increments in that same cycle.
  - rom_we is 0 in every other cycle.
  - rom_addr and rom_data hold their last values when rom_we = 0.
- Checksum: 8-bit accumulator cleared in HDR_HI before the first byte; adds every transferred byte with wrap-around.
- Timeout:
  - A cycle counter runs in HDR_LO, DATA_HI, DATA_LO and CHECK.
  - It clears on every transfer.
  - When it reaches TIMEOUT_CYCLES -> ERROR.
  - No timeout applies in HDR_HI.
- Outputs:
  - cpu_reset = 1 in every state except DONE. It falls in the same cycle done rises, which is the cycle after the CHK transfer.
  - busy = 1 in HDR_LO, DATA_HI, DATA_LO and CHECK.
  - done and error are mutually exclusive and hold until reload or reset.
- Reset values: in_ready = 1, rom_we = 0, rom_addr = 0, rom_data = 0, cpu_reset = 1, busy = 0, done = 0, error = 0, words_loaded = 0, state = HDR_HI.
- Reset mid-frame: aborts immediately. No further rom_we; the partially written ROM contents are left as-is; all state returns to reset values.
- Count == MAX_WORDS is legal: the last write goes to rom_addr = MAX_WORDS−1 with no address wrap.

Test Plan:
- Normal load: frame 00 02 | EC 10 | 00 07 | CHK = 0xFB, sent back-to-back:
  - two rom_we pulses, (addr 0, 0xEC10) then (addr 1, 0x0007);
  - done = 1 and cpu_reset = 0 exactly one cycle after the CHK transfer;
  - words_loaded = 2.
- Bad checksum: same frame with CHK = 0xFA -> error = 1, cpu_reset stays 1, done = 0, both ROM writes still occurred.
- Empty and oversize images:
  - 00 00 00 -> done with zero rom_we pulses;
  - with MAX_WORDS = 4, count 00 05 -> error after CNT_LO, in_ready = 0, no rom_we.
- Stall and timeout with TIMEOUT_CYCLES = 16:
  - in_valid gaps of 15 cycles between bytes -> successful load;
  - a gap of 16 cycles after a DATA_HI byte -> error, no write for the partial word.
- Reset and reload:
  - assert reset after the first word is written -> all outputs return to reset values the next cycle;
  - a fresh frame then loads from addr 0;
  - reload pulse from DONE -> cpu_reset = 1 next cycle and a second image loads correctly.
